// File: rtl/ultrasonic_ranger.sv
// Round-robin multi-channel ultrasonic ranger: fires one sensor per slot,
// measures the synchronised echo width in clk cycles and drives hysteretic crash flags.
module ultrasonic_ranger #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int TRIG_CYCLES    = 1000,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int HYST           = 500,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  thresh,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic [NUM_CH-1:0] is_crash,
    output logic              any_crash,
    output logic              meas_valid,
    output logic [CH_W-1:0]   meas_ch,
    output logic [CNT_W-1:0]  meas_width,
    output logic              meas_timeout
);

    // state     | meaning
    // IDLE      | parked, waiting for enable
    // TRIG      | trigger[ch] high for TRIG_CYCLES
    // WAIT_LOW  | wait for stale/stuck echo to clear
    // WAIT_RISE | wait for echo rising edge
    // MEASURE   | count echo-high cycles
    // HOLD      | idle out the remainder of the slot
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_LOW, WAIT_RISE, MEASURE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] echo_meta, es;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  slot_cnt, tcnt, width;
    logic [CNT_W:0]    release_lvl;
    logic              es_ch, trig_done, slot_done, timed_out;
    logic              start_slot, rise, post, post_timeout, advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta <= '0;
            es        <= '0;
        end else begin
            echo_meta <= echo;
            es        <= echo_meta;
        end
    end

    assign es_ch       = es[ch];
    assign trig_done   = (slot_cnt == CNT_W'(TRIG_CYCLES - 1));
    assign slot_done   = (slot_cnt == CNT_W'(PERIOD_CYCLES - 1));
    assign timed_out   = (tcnt == CNT_W'(TIMEOUT_CYCLES));
    assign release_lvl = {1'b0, thresh} + (CNT_W+1)'(HYST);
    assign any_crash   = |is_crash;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_slot   = 1'b0;
        rise         = 1'b0;
        post         = 1'b0;
        post_timeout = 1'b0;
        advance      = 1'b0;
        trigger      = '0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt  = TRIG;
                    start_slot = 1'b1;
                end
            end
            TRIG: begin
                trigger[ch] = 1'b1;
                if (trig_done) state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (timed_out) begin
                    post         = 1'b1;
                    post_timeout = 1'b1;
                    state_nxt    = HOLD;
                end else if (!es_ch) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (timed_out) begin
                    post         = 1'b1;
                    post_timeout = 1'b1;
                    state_nxt    = HOLD;
                end else if (es_ch) begin
                    rise      = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // a real falling edge wins over a coincident timeout
                if (!es_ch) begin
                    post      = 1'b1;
                    state_nxt = HOLD;
                end else if (timed_out) begin
                    post         = 1'b1;
                    post_timeout = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (slot_done) begin
                    advance    = 1'b1;
                    start_slot = enable;
                    state_nxt  = enable ? TRIG : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch           <= '0;
            slot_cnt     <= '0;
            tcnt         <= '0;
            width        <= '0;
            is_crash     <= '0;
            meas_valid   <= 1'b0;
            meas_ch      <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            if (start_slot)         slot_cnt <= '0;
            else if (state != IDLE) slot_cnt <= slot_cnt + CNT_W'(1);

            if (state == TRIG) begin
                tcnt  <= '0;
                width <= '0;
            end else if (state inside {WAIT_LOW, WAIT_RISE, MEASURE}) begin
                tcnt <= tcnt + CNT_W'(1);
            end

            // the rise cycle itself is already an echo-high cycle
            if (rise)                                width <= CNT_W'(1);
            else if (state == MEASURE && es_ch)      width <= width + CNT_W'(1);

            if (post) begin
                meas_valid   <= 1'b1;
                meas_ch      <= ch;
                meas_width   <= width;
                meas_timeout <= post_timeout;
                if (post_timeout)                         is_crash[ch] <= 1'b0;
                else if (width < thresh)                  is_crash[ch] <= 1'b1;
                else if ({1'b0, width} >= release_lvl)    is_crash[ch] <= 1'b0;
            end

            if (advance) ch <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger: stimulus pushes expected results from a
// slot-level reference model, an independent monitor checks each meas_valid strobe.
module tb_ultrasonic_ranger;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 32;
    localparam int TRIG    = 10;
    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 150;
    localparam int HYST    = 5;
    localparam int THRESH  = 50;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b1;
    logic [CNT_W-1:0]  thresh = CNT_W'(THRESH);
    logic [NUM_CH-1:0] echo   = '0;
    logic [NUM_CH-1:0] trigger, is_crash;
    logic              any_crash, meas_valid, meas_timeout;
    logic [0:0]        meas_ch;
    logic [CNT_W-1:0]  meas_width;

    ultrasonic_ranger #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT), .HYST(HYST)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .thresh(thresh), .echo(echo),
        .trigger(trigger), .is_crash(is_crash), .any_crash(any_crash),
        .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_width(meas_width),
        .meas_timeout(meas_timeout)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                ch;
        int                width;
        bit                to;
        logic [NUM_CH-1:0] crash;
        longint            at;
    } exp_t;

    exp_t              sbq[$];
    logic [NUM_CH-1:0] crash_m = '0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                exp_ch = 0;
    int                exp_gap = 1;
    longint            ref_cyc = 0, rise_cyc = 0, fall_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: crash decision from the raw echo width with threshold and hysteresis band.
    task automatic expect_result(input int c, input int w, input bit to, input longint at);
        exp_t e;
        if (to)                    crash_m[c] = 1'b0;
        else if (w < THRESH)       crash_m[c] = 1'b1;
        else if (w >= THRESH+HYST) crash_m[c] = 1'b0;
        e.ch = c; e.width = w; e.to = to; e.crash = crash_m; e.at = at;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_meas_valid: got strobe for ch %0d, required none", meas_ch);
                end else begin
                    e = sbq.pop_front();
                    chk("meas_ch", 64'(meas_ch), 64'(e.ch));
                    chk("meas_timeout", 64'(meas_timeout), 64'(e.to));
                    if (e.to) chk("timeout_width", 64'(meas_width), 64'(e.width));
                    else      chk_rng("meas_width", longint'(meas_width), e.width - 1, e.width + 1);
                    chk("is_crash", 64'(is_crash), 64'(e.crash));
                    chk("any_crash", 64'(any_crash), 64'(|e.crash));
                    if (e.to) chk("timeout_latency", 64'(cyc), 64'(e.at));
                    else      chk_rng("result_latency", cyc, e.at - 1, e.at + 1);
                end
            end
        end
    end

    task automatic wait_rise();
        int n = 0;
        while (trigger === '0 && n < 2*PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (trigger === '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL trigger_rise_wait: got no trigger in %0d cycles, required ch %0d", n, exp_ch);
        end
        rise_cyc = cyc;
        chk("trigger_onehot", 64'(trigger), 64'(1) << exp_ch);
        chk("trigger_gap", 64'(rise_cyc - ref_cyc), 64'(exp_gap));
        ref_cyc = rise_cyc;
        exp_gap = PERIOD;
    endtask

    task automatic wait_fall();
        int n = 0;
        while (trigger !== '0 && n < 4*TRIG) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
        chk("trigger_len", 64'(fall_cyc - rise_cyc), 64'(TRIG));
    endtask

    task automatic pulse(input int c, input int d, input int w, input bit drop_en);
        repeat (d) @(negedge clk);
        echo[c] = 1'b1;
        repeat (w / 2) @(negedge clk);
        if (drop_en) enable = 1'b0;
        repeat (w - w / 2) @(negedge clk);
        echo[c] = 1'b0;
    endtask

    task automatic slot_normal(input int d, input int w, input bit xtalk, input bit drop_en);
        int other;
        other = (exp_ch + 1) % NUM_CH;
        wait_rise();
        wait_fall();
        expect_result(exp_ch, w, 1'b0, fall_cyc + d + w + 3);
        fork
            pulse(exp_ch, d, w, drop_en);
            if (xtalk) pulse(other, 1, d + w + 5, 1'b0);
        join
        exp_ch = other;
    endtask

    task automatic slot_timeout(input bit stuck);
        wait_rise();
        if (stuck) echo[exp_ch] = 1'b1;
        wait_fall();
        expect_result(exp_ch, 0, 1'b1, fall_cyc + TIMEOUT + 1);
        if (stuck) begin
            repeat (170) @(negedge clk);
            echo[exp_ch] = 1'b0;
        end
        exp_ch = (exp_ch + 1) % NUM_CH;
    endtask

    initial begin
        int n, kind, d, w;
        bit xt;

        repeat (3) @(negedge clk);
        chk("rst_trigger", 64'(trigger), 64'(0));
        chk("rst_is_crash", 64'(is_crash), 64'(0));
        chk("rst_any_crash", 64'(any_crash), 64'(0));
        chk("rst_meas_valid", 64'(meas_valid), 64'(0));
        chk("rst_meas_width", 64'(meas_width), 64'(0));
        chk("rst_meas_ch", 64'(meas_ch), 64'(0));
        chk("rst_meas_timeout", 64'(meas_timeout), 64'(0));
        reset   = 1'b0;
        ref_cyc = cyc;
        exp_gap = 1;

        slot_normal(20, 40, 1'b0, 1'b0);   // ch0 crash
        slot_timeout(1'b0);                // ch1 no echo
        slot_normal(20, 52, 1'b0, 1'b0);   // ch0 inside band: hold
        slot_timeout(1'b1);                // ch1 stuck high
        slot_normal(15, 56, 1'b1, 1'b0);   // ch0 release, crosstalk on ch1
        slot_normal(10, 30, 1'b0, 1'b0);   // ch1 crash
        slot_normal(10, 20, 1'b0, 1'b0);   // ch0 crash
        slot_normal(10, 40, 1'b0, 1'b1);   // ch1, enable dropped mid-measure

        n = 0;
        repeat (2*PERIOD) begin
            @(negedge clk);
            if (trigger !== '0) n++;
        end
        chk("idle_no_trigger", 64'(n), 64'(0));
        chk("idle_pending", 64'(sbq.size()), 64'(0));
        enable  = 1'b1;
        ref_cyc = cyc;
        exp_gap = 1;

        wait_rise();
        wait_fall();
        repeat (10) @(negedge clk);
        echo[0] = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_trigger", 64'(trigger), 64'(0));
        chk("midrst_is_crash", 64'(is_crash), 64'(0));
        chk("midrst_any_crash", 64'(any_crash), 64'(0));
        chk("midrst_meas_valid", 64'(meas_valid), 64'(0));
        chk("midrst_meas_width", 64'(meas_width), 64'(0));
        echo    = '0;
        crash_m = '0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        ref_cyc = cyc;
        exp_gap = 1;
        exp_ch  = 0;

        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                slot_timeout(1'b0);
            end else if (kind == 1) begin
                slot_timeout(1'b1);
            end else begin
                d  = $urandom_range(2, 30);
                w  = $urandom_range(1, 100);
                while (w inside {THRESH-1, THRESH, THRESH+HYST-1, THRESH+HYST})
                    w = $urandom_range(1, 100);
                xt = ($urandom_range(0, 3) == 0);
                slot_normal(d, w, xt, 1'b0);
            end
        end

        n = 0;
        while (sbq.size() != 0 && n < 2*PERIOD) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
